// File: rtl/sata_user_arbiter_if.sv
// SATA user-core bus: address/data/strobes toward the core,
// back-pressure, write completion and read data back from it.
//   master: arbiter side (drives ADDRESS_IN, DATA_IN, WR_EN, RD_EN)
//   slave : core side (drives WR_HOLD_OUT, RD_HOLD_OUT, WR_DONE, DATA_OUT)
interface sata_user_arbiter_if #(
    parameter int ADDR_W = 57,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ADDRESS_IN;
    logic [DATA_W-1:0] DATA_IN;
    logic              WR_EN;
    logic              RD_EN;
    logic              WR_HOLD_OUT;
    logic              RD_HOLD_OUT;
    logic              WR_DONE;
    logic [DATA_W-1:0] DATA_OUT;

    modport master (
        output ADDRESS_IN, DATA_IN, WR_EN, RD_EN,
        input  WR_HOLD_OUT, RD_HOLD_OUT, WR_DONE, DATA_OUT
    );

    modport slave (
        input  ADDRESS_IN, DATA_IN, WR_EN, RD_EN,
        output WR_HOLD_OUT, RD_HOLD_OUT, WR_DONE, DATA_OUT
    );
endinterface

// File: rtl/sata_user_arbiter.sv
// Two-requester round-robin arbiter in front of the SATA user core.
// Ports: USR_CLOCK/USR_RESET_N; REQn_* requester side (REQ, RNW, ADDR,
// WDATA, VALID in; GNT, READY, RVALID out); shared RDATA; core bus via
// sata_user_arbiter_if.master; ERR_CLR in; BUSY, ACTIVE_ID, TIMEOUT_ERR out.
module sata_user_arbiter #(
    parameter int ADDR_W    = 57,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 256,
    parameter int TIMEOUT   = 4095
) (
    input  logic              USR_CLOCK,
    input  logic              USR_RESET_N,
    input  logic              REQ0_REQ,
    input  logic              REQ1_REQ,
    input  logic              REQ0_RNW,
    input  logic              REQ1_RNW,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ0_WDATA,
    input  logic [DATA_W-1:0] REQ1_WDATA,
    input  logic              REQ0_VALID,
    input  logic              REQ1_VALID,
    output logic              REQ0_GNT,
    output logic              REQ1_GNT,
    output logic              REQ0_READY,
    output logic              REQ1_READY,
    output logic              REQ0_RVALID,
    output logic              REQ1_RVALID,
    output logic [DATA_W-1:0] RDATA,
    sata_user_arbiter_if.master core,
    input  logic              ERR_CLR,
    output logic              BUSY,
    output logic              ACTIVE_ID,
    output logic              TIMEOUT_ERR
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, XFER, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, rnw_q, rr_q;
    logic              done_seen_q, gnt_q, err_q;
    logic              rv0_q, rv1_q;
    logic [BW-1:0]     beat_q;
    logic [TW-1:0]     to_q;
    logic [DATA_W-1:0] rdata_q;

    logic own_req, own_valid, hold, in_xfer, in_wait;
    logic ready, beat, beat_last, any_req, grant_id;
    logic grant, xfer_exit, to_fire, wr_en, rd_en;

    assign own_req   = owner_q ? REQ1_REQ : REQ0_REQ;
    assign own_valid = owner_q ? REQ1_VALID : REQ0_VALID;
    assign hold      = rnw_q ? core.RD_HOLD_OUT : core.WR_HOLD_OUT;
    assign in_xfer   = (state_q == XFER);
    assign in_wait   = (state_q == WAIT_DONE);
    assign ready     = in_xfer & ~hold;
    assign beat      = ready & own_valid;
    // The beat that fills the burst still issues, then ownership ends.
    assign beat_last = beat & (beat_q == BW'(MAX_BURST - 1));
    assign any_req   = REQ0_REQ | REQ1_REQ;
    assign grant_id  = (REQ0_REQ & REQ1_REQ) ? rr_q : REQ1_REQ;
    assign grant     = (state_q == IDLE) & any_req;
    assign xfer_exit = in_xfer & (~own_req | beat_last);
    assign to_fire   = in_wait & ~core.WR_DONE & ~done_seen_q
                     & (to_q == TW'(TIMEOUT - 1));
    assign wr_en     = beat & ~rnw_q;
    assign rd_en     = beat & rnw_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (any_req) state_d = XFER;
            XFER:
                if (xfer_exit) begin
                    // A write that moved no data has nothing to wait for.
                    if (rnw_q || (beat_q == '0 && !beat))
                        state_d = IDLE;
                    else
                        state_d = WAIT_DONE;
                end
            WAIT_DONE:
                if (core.WR_DONE || done_seen_q || to_fire)
                    state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge USR_CLOCK or negedge USR_RESET_N) begin
        if (!USR_RESET_N) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rnw_q       <= 1'b0;
            rr_q        <= 1'b0;
            done_seen_q <= 1'b0;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
            rv0_q       <= 1'b0;
            rv1_q       <= 1'b0;
            beat_q      <= '0;
            to_q        <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q     <= grant_id;
                rnw_q       <= grant_id ? REQ1_RNW : REQ0_RNW;
                beat_q      <= '0;
                done_seen_q <= 1'b0;
                gnt_q       <= 1'b1;
            end else if (state_d == IDLE) begin
                gnt_q <= 1'b0;
            end
            if (beat)
                beat_q <= beat_q + BW'(1);
            // Completion may arrive before the write burst even ends.
            if (in_xfer && !rnw_q && core.WR_DONE)
                done_seen_q <= 1'b1;
            if (xfer_exit)
                rr_q <= ~owner_q;
            if (in_wait)
                to_q <= to_q + TW'(1);
            else
                to_q <= '0;
            if (to_fire)
                err_q <= 1'b1;
            else if (ERR_CLR)
                err_q <= 1'b0;
            // owner_q is stable until the next grant, so a trailing
            // read beat is still routed to the requester that issued it.
            rv0_q <= rd_en & ~owner_q;
            rv1_q <= rd_en & owner_q;
            if (rd_en)
                rdata_q <= core.DATA_OUT;
        end
    end

    assign core.ADDRESS_IN = in_xfer ? (owner_q ? REQ1_ADDR : REQ0_ADDR) : '0;
    assign core.DATA_IN    = in_xfer ? (owner_q ? REQ1_WDATA : REQ0_WDATA) : '0;
    assign core.WR_EN      = wr_en;
    assign core.RD_EN      = rd_en;

    assign REQ0_GNT    = gnt_q & ~owner_q;
    assign REQ1_GNT    = gnt_q & owner_q;
    assign REQ0_READY  = ready & ~owner_q;
    assign REQ1_READY  = ready & owner_q;
    assign REQ0_RVALID = rv0_q;
    assign REQ1_RVALID = rv1_q;
    assign RDATA       = rdata_q;
    assign BUSY        = (state_q != IDLE);
    assign ACTIVE_ID   = owner_q;
    assign TIMEOUT_ERR = err_q;
endmodule
